ws2812_frame_ctrl: RTL and testbench

Frame sequencer for the WS2812 LED chain. Reads up to N_LEDS 24-bit GRB pixels from an external pixel buffer, serializes each pixel MSB-first, and hands one bit at a time to the chain's bit-waveform encoder over a valid/ready handshake. After the last bit it asserts the latch (reset-low) period, then reports frame completion. Sits between the pixel buffer / frame-update logic and the single-wire `rgbchain` encoder.

---
 rtl/ws2812_frame_ctrl.sv | 132 +++++++++++++
 tb/tb_ws2812_frame_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_frame_ctrl.sv
// ws2812_frame_ctrl
// Frame sequencer for a WS2812 LED chain. Fetches each 24-bit GRB pixel from
// an external buffer, feeds its bits MSB-first to the bit-waveform encoder
// over valid/ready, then holds the latch (reset-low) period and pulses done.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start, no outputs active
// S_FETCH | pix_rd strobe for pixel idx (buffer answers next cycle)
// S_WAIT  | pix_data valid, captured into the shift register
// S_SHIFT | presenting shreg[23] to the encoder until 24 bits accepted
// S_LATCH | latch period, lcnt counts LATCH_CYCLES cycles
//
// Every output is decoded from state/registers only, so bit_ready has no
// combinational route to bit_valid or bit_data.

module ws2812_frame_ctrl #(
    parameter int N_LEDS       = 8,
    parameter int ADDR_W       = 3,
    parameter int LATCH_CYCLES = 5000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] pix_addr,
    output logic              pix_rd,
    input  logic [23:0]       pix_data,
    output logic              bit_valid,
    output logic              bit_data,
    input  logic              bit_ready,
    output logic              latch
);

    // A one-cycle latch still needs a one-bit counter.
    localparam int LCNT_W = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_SHIFT = 3'd3;
    localparam logic [2:0] S_LATCH = 3'd4;

    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(N_LEDS - 1);
    localparam logic [LCNT_W-1:0] LAST_LCNT = LCNT_W'(LATCH_CYCLES - 1);
    localparam logic [4:0]        LAST_BIT  = 5'd23;

    logic [2:0]        state;
    logic [ADDR_W-1:0] idx;
    logic [23:0]       shreg;
    logic [4:0]        bitcnt;
    logic [LCNT_W-1:0] lcnt;
    logic              done_r;
    logic              bit_take;

    // A bit leaves only when it is actually being offered.
    assign bit_take = (state == S_SHIFT) && bit_ready;

    // Frame sequencing: state, pixel index, shift register and counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            idx    <= '0;
            shreg  <= '0;
            bitcnt <= '0;
            lcnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        idx   <= '0;
                        state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    shreg  <= pix_data;
                    bitcnt <= '0;
                    state  <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (bit_take) begin
                        shreg  <= {shreg[22:0], 1'b0};
                        bitcnt <= bitcnt + 5'd1;
                        if (bitcnt == LAST_BIT) begin
                            if (idx == LAST_IDX) begin
                                lcnt  <= '0;
                                state <= S_LATCH;
                            end else begin
                                idx   <= idx + 1'b1;
                                state <= S_FETCH;
                            end
                        end
                    end
                end
                S_LATCH: begin
                    lcnt <= lcnt + 1'b1;
                    if (lcnt == LAST_LCNT) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // done is registered so it lands in the first IDLE cycle after the latch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done_r <= 1'b0;
        end else begin
            done_r <= (state == S_LATCH) && (lcnt == LAST_LCNT);
        end
    end

    // Output decode; the address is forced to zero outside the read strobe.
    always_comb begin
        busy      = (state != S_IDLE);
        pix_rd    = (state == S_FETCH);
        pix_addr  = (state == S_FETCH) ? idx : '0;
        bit_valid = (state == S_SHIFT);
        bit_data  = (state == S_SHIFT) && shreg[23];
        latch     = (state == S_LATCH);
        done      = done_r;
    end

endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// Self-checking bench for ws2812_frame_ctrl: an 2-LED/10-cycle-latch instance
// and a 1-LED/1-cycle-latch instance, each with a behavioural pixel buffer.
module tb_ws2812_frame_ctrl;

    localparam int NA  = 2;
    localparam int LCA = 10;
    localparam int NB  = 1;
    localparam int LCB = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        a_start, a_busy, a_done, a_pix_rd, a_bit_valid, a_bit_data, a_bit_ready, a_latch;
    logic [0:0]  a_pix_addr;
    logic [23:0] a_pix_data;
    logic        b_start, b_busy, b_done, b_pix_rd, b_bit_valid, b_bit_data, b_bit_ready, b_latch;
    logic [0:0]  b_pix_addr;
    logic [23:0] b_pix_data;

    logic [23:0] mem_a [NA];
    logic [23:0] mem_b;

    int checks   = 0;
    int failures = 0;

    ws2812_frame_ctrl #(.N_LEDS(NA), .ADDR_W(1), .LATCH_CYCLES(LCA)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .busy(a_busy), .done(a_done),
        .pix_addr(a_pix_addr), .pix_rd(a_pix_rd), .pix_data(a_pix_data),
        .bit_valid(a_bit_valid), .bit_data(a_bit_data), .bit_ready(a_bit_ready),
        .latch(a_latch)
    );

    ws2812_frame_ctrl #(.N_LEDS(NB), .ADDR_W(1), .LATCH_CYCLES(LCB)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .busy(b_busy), .done(b_done),
        .pix_addr(b_pix_addr), .pix_rd(b_pix_rd), .pix_data(b_pix_data),
        .bit_valid(b_bit_valid), .bit_data(b_bit_data), .bit_ready(b_bit_ready),
        .latch(b_latch)
    );

    // Pixel buffers: data one cycle after the read strobe, noise otherwise.
    always @(posedge clk) begin
        a_pix_data <= a_pix_rd ? mem_a[int'(a_pix_addr)] : 24'($urandom);
        b_pix_data <= b_pix_rd ? mem_b : 24'($urandom);
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_a(input string tag);
        chkn(tag, int'({a_busy, a_done, a_pix_rd, a_bit_valid, a_bit_data, a_latch, a_pix_addr}), 0);
    endtask

    // One frame on instance A. Caller has set a_start=1 at a falling edge.
    // mode 0: bit_ready high; 1: 3-cycle stall on every 5th bit; 2: random ready.
    // Expected timing is the tied-high schedule pushed out by every stall cycle.
    task automatic run_a(input int mode, input bit pulse_start, input bit chain, input int tail);
        int   c, exp_done, stalls, nout, npix, hold_cnt;
        bit   stalled;
        logic prev_data;
        logic bits [NA*24];
        for (int i = 0; i < NA*24; i++) bits[i] = mem_a[i/24][23-(i%24)];
        c = 0; stalls = 0; nout = 0; npix = 0; hold_cnt = 0; stalled = 0; prev_data = 1'b0;
        exp_done = 26*NA + LCA + 1;
        @(posedge clk);
        while (c < exp_done + tail && c < 3000) begin
            @(negedge clk);
            c++;
            if (stalled) begin
                chk1("stall_valid", a_bit_valid, 1'b1);
                chk1("stall_data", a_bit_data, prev_data);
            end
            chk1("done", a_done, c == exp_done);
            chk1("busy", a_busy, c < exp_done);
            chk1("latch", a_latch, (c >= exp_done - LCA) && (c < exp_done));
            chk1("exclusive", $countones({a_pix_rd, a_bit_valid, a_latch}) <= 1, 1'b1);
            if (mode == 0) begin
                chk1("pix_rd_time", a_pix_rd, (c <= 26*NA) && ((c-1) % 26 == 0));
                chk1("bit_valid_time", a_bit_valid, (c <= 26*NA) && ((c-1) % 26 >= 2));
            end
            if (a_pix_rd) begin
                chkn("pix_addr", int'(a_pix_addr), npix);
                npix++;
            end
            if (a_bit_valid) chk1("bit_data", a_bit_data, (nout < NA*24) ? bits[nout] : 1'b0);
            case (mode)
                0:       a_bit_ready = 1'b1;
                1:       a_bit_ready = !(a_bit_valid && (nout % 5 == 0) && (hold_cnt < 3));
                default: a_bit_ready = 1'($urandom_range(0, 1));
            endcase
            stalled = a_bit_valid && !a_bit_ready;
            if (a_bit_valid) begin
                if (a_bit_ready) begin
                    nout++;
                    hold_cnt = 0;
                end else begin
                    stalls++;
                    hold_cnt++;
                    exp_done++;
                end
            end
            prev_data = a_bit_data;
            a_start = (pulse_start && (c == 5 || c == 40)) || (chain && c == exp_done);
            if (chain && c == exp_done) break;
        end
        chkn("bits_out", nout, NA*24);
        chkn("pixels_read", npix, NA);
        if (mode == 1) chkn("stall_total", stalls, 30);
    endtask

    // One frame on instance B (single pixel, single-cycle latch).
    task automatic run_b();
        b_start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 31; c++) begin
            @(negedge clk);
            b_start = 1'b0;
            chk1("b_pix_rd", b_pix_rd, c == 1);
            chk1("b_pix_addr", b_pix_addr[0], 1'b0);
            chk1("b_bit_valid", b_bit_valid, (c >= 3) && (c <= 26));
            chk1("b_latch", b_latch, c == 27);
            chk1("b_done", b_done, c == 28);
            chk1("b_busy", b_busy, c <= 27);
            if (c >= 3 && c <= 26) chk1("b_bit_data", b_bit_data, mem_b[26-c]);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a_start = 1'b0; b_start = 1'b0;
        a_bit_ready = 1'b1; b_bit_ready = 1'b1;
        mem_a[0] = 24'hFF0081;
        mem_a[1] = 24'h00A55A;
        mem_b    = 24'h800001;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_idle_a("reset_a");
        chkn("reset_b", int'({b_busy, b_done, b_pix_rd, b_bit_valid, b_bit_data, b_latch, b_pix_addr}), 0);
        rst_n = 1'b1;

        // Directed frame with ignored start pulses, chained into a second frame.
        @(negedge clk);
        a_start = 1'b1;
        run_a(0, 1'b1, 1'b1, 0);
        run_a(0, 1'b0, 1'b0, 3);

        // Periodic stalls on the same pixels.
        @(negedge clk);
        a_start = 1'b1;
        run_a(1, 1'b0, 1'b0, 2);

        // Random pixels with random ready.
        repeat (3) begin
            mem_a[0] = 24'($urandom);
            mem_a[1] = 24'($urandom);
            @(negedge clk);
            a_start = 1'b1;
            run_a(2, 1'b0, 1'b0, 2);
        end

        // Reset for one edge in cycle 30, then a fresh frame.
        mem_a[0] = 24'($urandom);
        mem_a[1] = 24'($urandom);
        a_bit_ready = 1'b1;
        @(negedge clk);
        a_start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            a_start = 1'b0;
            if (c == 30) rst_n = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        chk_idle_a("abort_outputs");
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            chk1("abort_no_done", a_done | a_busy | a_latch, 1'b0);
        end
        @(negedge clk);
        a_start = 1'b1;
        run_a(0, 1'b0, 1'b0, 2);

        // Single-LED instance: directed pixel then a random one.
        @(negedge clk);
        run_b();
        mem_b = 24'($urandom);
        @(negedge clk);
        run_b();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
